// File: rtl/retire_trace_checker.sv
// rtl/retire_trace_checker.sv - multi-lane retire vs golden trace checker
//
// Compares up to RETIRE_W retired register writes per cycle against golden
// records held in an internal FIFO. It latches the first failure, counts
// matched instructions and resolves good/bad trap from the result word.
//
// Ports:
//   sys_clk, sys_reset       clock, asynchronous active-high reset
//   rt_valid/pc/waddr/wdata  retire lanes, lane 0 oldest, lane k at slice k
//   gd_valid/gd_ready        golden push handshake
//   gd_pc/wdata/mask/waddr   golden record fields, gd_last marks final record
//   res_valid/res_word       result word (0 good trap, 1 bad trap)
//   done/pass/err_code       verdict (err_code: 1 mismatch, 2 underflow, 3 bad trap)
//   err_*                    first-failure capture of retire and golden fields
//   check_cnt                saturating count of matched instructions

module retire_trace_checker #(
    parameter int RETIRE_W = 2,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 32
) (
    input  logic                    sys_clk,
    input  logic                    sys_reset,
    input  logic [RETIRE_W-1:0]     rt_valid,
    input  logic [32*RETIRE_W-1:0]  rt_pc,
    input  logic [5*RETIRE_W-1:0]   rt_waddr,
    input  logic [32*RETIRE_W-1:0]  rt_wdata,
    input  logic                    gd_valid,
    output logic                    gd_ready,
    input  logic [31:0]             gd_pc,
    input  logic [31:0]             gd_wdata,
    input  logic [31:0]             gd_mask,
    input  logic [4:0]              gd_waddr,
    input  logic                    gd_last,
    input  logic                    res_valid,
    input  logic [31:0]             res_word,
    output logic                    done,
    output logic                    pass,
    output logic [1:0]              err_code,
    output logic [31:0]             err_pc,
    output logic [31:0]             err_wdata,
    output logic [31:0]             err_gold_pc,
    output logic [31:0]             err_gold_wdata,
    output logic [4:0]              err_waddr,
    output logic [4:0]              err_gold_waddr,
    output logic [CNT_W-1:0]        check_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL} state_t;

    state_t state_q, state_d;
    logic [1:0] code_d;

    logic [31:0]      fifo_pc    [DEPTH];
    logic [31:0]      fifo_wdata [DEPTH];
    logic [31:0]      fifo_mask  [DEPTH];
    logic [4:0]       fifo_waddr [DEPTH];
    logic [DEPTH-1:0] fifo_last;

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [OW-1:0] occ;
    logic          trace_end;
    logic          last_pushed;
    logic          push;

    logic [OW-1:0] pops, match_cnt, idx;
    logic [PW-1:0] ent;
    logic          stop, mis, unc, end_set;
    logic [31:0]   cap_pc, cap_wdata, cap_gpc, cap_gwdata;
    logic [4:0]    cap_waddr, cap_gwaddr;
    logic [CNT_W:0] cnt_sum;

    // No same-cycle pop credit; the loader is also cut off once its final
    // record has been accepted.
    assign gd_ready = (occ < OW'(DEPTH)) && !last_pushed;
    assign push     = gd_valid && gd_ready;
    assign done     = (state_q != S_RUN);
    assign pass     = (state_q == S_PASS);

    // Lane walk: each checkable lane takes the next unconsumed golden entry.
    // Walking stops at the first uncovered lane or once the final record is
    // consumed, so any mismatch recorded earlier is always in a lower lane.
    always_comb begin
        pops       = '0;
        match_cnt  = '0;
        idx        = '0;
        ent        = '0;
        stop       = trace_end || (state_q != S_RUN);
        mis        = 1'b0;
        unc        = 1'b0;
        end_set    = 1'b0;
        cap_pc     = '0;
        cap_wdata  = '0;
        cap_waddr  = '0;
        cap_gpc    = '0;
        cap_gwdata = '0;
        cap_gwaddr = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            if (!stop && rt_valid[k] && (rt_waddr[5*k +: 5] != 5'd0)) begin
                if (idx >= occ) begin
                    unc  = 1'b1;
                    stop = 1'b1;
                    if (!mis) begin
                        cap_pc    = rt_pc[32*k +: 32];
                        cap_wdata = rt_wdata[32*k +: 32];
                        cap_waddr = rt_waddr[5*k +: 5];
                    end
                end else begin
                    ent  = rd_ptr + idx[PW-1:0];
                    pops = pops + OW'(1);
                    idx  = idx + OW'(1);
                    if ((rt_pc[32*k +: 32] == fifo_pc[ent]) &&
                        (rt_waddr[5*k +: 5] == fifo_waddr[ent]) &&
                        (((rt_wdata[32*k +: 32] ^ fifo_wdata[ent]) & fifo_mask[ent]) == 32'd0)) begin
                        match_cnt = match_cnt + OW'(1);
                    end else if (!mis) begin
                        mis        = 1'b1;
                        cap_pc     = rt_pc[32*k +: 32];
                        cap_wdata  = rt_wdata[32*k +: 32];
                        cap_waddr  = rt_waddr[5*k +: 5];
                        cap_gpc    = fifo_pc[ent];
                        cap_gwdata = fifo_wdata[ent];
                        cap_gwaddr = fifo_waddr[ent];
                    end
                    if (fifo_last[ent]) begin
                        end_set = 1'b1;
                        stop    = 1'b1;
                    end
                end
            end
        end
    end

    // Retire errors outrank a trap seen in the same cycle.
    always_comb begin
        state_d = state_q;
        code_d  = 2'd0;
        if (state_q == S_RUN) begin
            if (mis) begin
                state_d = S_FAIL;
                code_d  = 2'd1;
            end else if (unc) begin
                state_d = S_FAIL;
                code_d  = 2'd2;
            end else if (res_valid && (res_word == 32'd0)) begin
                state_d = S_PASS;
            end else if (res_valid && (res_word == 32'd1)) begin
                state_d = S_FAIL;
                code_d  = 2'd3;
            end
        end
    end

    assign cnt_sum = {1'b0, check_cnt} + (CNT_W+1)'(match_cnt);

    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= gd_pc;
            fifo_wdata[wr_ptr] <= gd_wdata;
            fifo_mask[wr_ptr]  <= gd_mask;
            fifo_waddr[wr_ptr] <= gd_waddr;
            fifo_last[wr_ptr]  <= gd_last;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q        <= S_RUN;
            err_code       <= 2'd0;
            err_pc         <= '0;
            err_wdata      <= '0;
            err_waddr      <= '0;
            err_gold_pc    <= '0;
            err_gold_wdata <= '0;
            err_gold_waddr <= '0;
            check_cnt      <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            occ            <= '0;
            trace_end      <= 1'b0;
            last_pushed    <= 1'b0;
        end else begin
            state_q   <= state_d;
            occ       <= occ + OW'(push) - pops;
            rd_ptr    <= rd_ptr + pops[PW-1:0];
            trace_end <= trace_end | end_set;
            if (push) begin
                wr_ptr      <= wr_ptr + PW'(1);
                last_pushed <= last_pushed | gd_last;
            end
            check_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
            if (state_d == S_FAIL && state_q == S_RUN) begin
                err_code       <= code_d;
                err_pc         <= cap_pc;
                err_wdata      <= cap_wdata;
                err_waddr      <= cap_waddr;
                err_gold_pc    <= cap_gpc;
                err_gold_wdata <= cap_gwdata;
                err_gold_waddr <= cap_gwaddr;
            end
        end
    end

endmodule

// File: tb/tb_retire_trace_checker.sv
// tb/tb_retire_trace_checker.sv - directed self-checking bench for retire_trace_checker

module tb_retire_trace_checker;

    logic        sys_clk;
    logic        sys_reset;
    logic [1:0]  rt_valid;
    logic [63:0] rt_pc;
    logic [9:0]  rt_waddr;
    logic [63:0] rt_wdata;
    logic        gd_valid;
    logic        gd_ready;
    logic [31:0] gd_pc, gd_wdata, gd_mask;
    logic [4:0]  gd_waddr;
    logic        gd_last;
    logic        res_valid;
    logic [31:0] res_word;
    logic        done, pass;
    logic [1:0]  err_code;
    logic [31:0] err_pc, err_wdata, err_gold_pc, err_gold_wdata;
    logic [4:0]  err_waddr, err_gold_waddr;
    logic [31:0] check_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    retire_trace_checker #(.RETIRE_W(2), .DEPTH(16), .CNT_W(32)) dut (
        .sys_clk(sys_clk), .sys_reset(sys_reset),
        .rt_valid(rt_valid), .rt_pc(rt_pc), .rt_waddr(rt_waddr), .rt_wdata(rt_wdata),
        .gd_valid(gd_valid), .gd_ready(gd_ready), .gd_pc(gd_pc), .gd_wdata(gd_wdata),
        .gd_mask(gd_mask), .gd_waddr(gd_waddr), .gd_last(gd_last),
        .res_valid(res_valid), .res_word(res_word),
        .done(done), .pass(pass), .err_code(err_code),
        .err_pc(err_pc), .err_wdata(err_wdata), .err_gold_pc(err_gold_pc),
        .err_gold_wdata(err_gold_wdata), .err_waddr(err_waddr),
        .err_gold_waddr(err_gold_waddr), .check_cnt(check_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        rt_valid  = '0;
        gd_valid  = 1'b0;
        gd_last   = 1'b0;
        res_valid = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic [4:0] a,
                            input logic [31:0] d, input logic [31:0] m, input logic l);
        gd_valid = 1'b1;
        gd_pc    = pc;
        gd_waddr = a;
        gd_wdata = d;
        gd_mask  = m;
        gd_last  = l;
    endtask

    task automatic push(input logic [31:0] pc, input logic [4:0] a,
                        input logic [31:0] d, input logic [31:0] m, input logic l);
        set_push(pc, a, d, m, l);
        tick();
    endtask

    task automatic set_lane(input int k, input logic [31:0] pc,
                            input logic [4:0] a, input logic [31:0] d);
        rt_valid[k]         = 1'b1;
        rt_pc[32*k +: 32]   = pc;
        rt_waddr[5*k +: 5]  = a;
        rt_wdata[32*k +: 32] = d;
    endtask

    task automatic trap(input logic [31:0] w);
        res_valid = 1'b1;
        res_word  = w;
        tick();
    endtask

    task automatic do_reset();
        sys_reset = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_reset = 1'b0;
    endtask

    initial begin
        sys_reset = 1'b0;
        rt_valid = '0; rt_pc = '0; rt_waddr = '0; rt_wdata = '0;
        gd_valid = 1'b0; gd_pc = '0; gd_wdata = '0; gd_mask = '0; gd_waddr = '0; gd_last = 1'b0;
        res_valid = 1'b0; res_word = 32'h2;
        do_reset();

        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_code", err_code, 0);
        check("rst_cnt", check_cnt, 0);
        check("rst_ready", gd_ready, 1);

        // Four matching records retired two per cycle, then good trap.
        for (int i = 0; i < 4; i++)
            push(32'h100 + 4*i, 5'(i + 1), 32'h1000 + i, 32'hFFFF_FFFF, 1'b0);
        set_lane(0, 32'h100, 5'd1, 32'h1000);
        set_lane(1, 32'h104, 5'd2, 32'h1001);
        tick();
        set_lane(0, 32'h108, 5'd3, 32'h1002);
        set_lane(1, 32'h10C, 5'd4, 32'h1003);
        tick();
        check("t1_cnt", check_cnt, 4);
        check("t1_occ", dut.occ, 0);
        check("t1_done_pre", done, 0);
        trap(32'd0);
        check("t1_done", done, 1);
        check("t1_pass", pass, 1);
        check("t1_code", err_code, 0);

        // Lane 1 data mismatch with full mask.
        do_reset();
        push(32'h200, 5'd1, 32'h11, 32'hFFFF_FFFF, 1'b0);
        push(32'h204, 5'd2, 32'hDEAD_BEEE, 32'hFFFF_FFFF, 1'b0);
        set_lane(0, 32'h200, 5'd1, 32'h11);
        set_lane(1, 32'h204, 5'd2, 32'hDEAD_BEEF);
        tick();
        check("t2_done", done, 1);
        check("t2_pass", pass, 0);
        check("t2_code", err_code, 1);
        check("t2_err_pc", err_pc, 32'h204);
        check("t2_err_wdata", err_wdata, 32'hDEAD_BEEF);
        check("t2_err_waddr", err_waddr, 2);
        check("t2_gold_pc", err_gold_pc, 32'h204);
        check("t2_gold_wdata", err_gold_wdata, 32'hDEAD_BEEE);
        check("t2_gold_waddr", err_gold_waddr, 2);
        check("t2_cnt", check_cnt, 1);

        // Same data, bit 0 masked off.
        do_reset();
        push(32'h200, 5'd1, 32'h11, 32'hFFFF_FFFF, 1'b0);
        push(32'h204, 5'd2, 32'hDEAD_BEEE, 32'hFFFF_FFFE, 1'b0);
        set_lane(0, 32'h200, 5'd1, 32'h11);
        set_lane(1, 32'h204, 5'd2, 32'hDEAD_BEEF);
        tick();
        check("t2m_done", done, 0);
        check("t2m_code", err_code, 0);
        check("t2m_cnt", check_cnt, 2);

        // Lane 0 writes x0, lane 1 takes the head entry.
        do_reset();
        push(32'h300, 5'd5, 32'h55, 32'hFFFF_FFFF, 1'b0);
        push(32'h304, 5'd6, 32'h66, 32'hFFFF_FFFF, 1'b0);
        set_lane(0, 32'h999, 5'd0, 32'h1234);
        set_lane(1, 32'h300, 5'd5, 32'h55);
        tick();
        check("t3_cnt", check_cnt, 1);
        check("t3_occ", dut.occ, 1);
        check("t3_done", done, 0);

        // Lane 1 uncovered: underflow.
        set_lane(0, 32'h304, 5'd6, 32'h66);
        set_lane(1, 32'h308, 5'd7, 32'h77);
        tick();
        check("t4_code", err_code, 2);
        check("t4_done", done, 1);
        check("t4_err_pc", err_pc, 32'h308);
        check("t4_err_waddr", err_waddr, 7);
        check("t4_err_wdata", err_wdata, 32'h77);
        check("t4_gold_pc", err_gold_pc, 0);
        check("t4_gold_wdata", err_gold_wdata, 0);
        check("t4_cnt", check_cnt, 2);

        // Retires beyond the final golden record are unchecked.
        do_reset();
        push(32'h400, 5'd1, 32'hA, 32'hFFFF_FFFF, 1'b1);
        check("t4l_ready", gd_ready, 0);
        set_lane(0, 32'h400, 5'd1, 32'hA);
        set_lane(1, 32'h404, 5'd2, 32'hBAD);
        tick();
        check("t4l_cnt", check_cnt, 1);
        check("t4l_code", err_code, 0);
        set_lane(0, 32'h500, 5'd3, 32'h0);
        set_lane(1, 32'h504, 5'd4, 32'h0);
        tick();
        check("t4e_cnt", check_cnt, 1);
        check("t4e_done", done, 0);
        check("t4e_code", err_code, 0);

        // Fill, drain two per cycle, push across the wrap point.
        do_reset();
        for (int i = 0; i < 16; i++)
            push(32'h600 + 4*i, 5'(i + 1), 32'(i * 32'h11), 32'hFFFF_FFFF, 1'b0);
        check("t5_full_ready", gd_ready, 0);
        check("t5_full_occ", dut.occ, 16);
        for (int j = 0; j < 8; j++) begin
            set_lane(0, 32'h600 + 8*j, 5'(2*j + 1), 32'((2*j) * 32'h11));
            set_lane(1, 32'h604 + 8*j, 5'(2*j + 2), 32'((2*j + 1) * 32'h11));
            if (j == 0) set_push(32'hBAD0, 5'd9, 32'h0, 32'hFFFF_FFFF, 1'b0);
            if (j == 1) set_push(32'h700, 5'd17, 32'h7777, 32'hFFFF_FFFF, 1'b0);
            tick();
            if (j == 0) check("t5_occ_j0", dut.occ, 14);
            if (j == 1) check("t5_occ_j1", dut.occ, 13);
        end
        check("t5_cnt16", check_cnt, 16);
        check("t5_occ_left", dut.occ, 1);
        set_lane(0, 32'h700, 5'd17, 32'h7777);
        tick();
        check("t5_cnt17", check_cnt, 17);
        check("t5_done_pre", done, 0);
        trap(32'd1);
        check("t5_code", err_code, 3);
        check("t5_done", done, 1);
        check("t5_pass", pass, 0);
        check("t5_err_pc", err_pc, 0);

        // Asynchronous reset between clock edges.
        sys_reset = 1'b1;
        #1;
        check("ar_done", done, 0);
        check("ar_code", err_code, 0);
        check("ar_cnt", check_cnt, 0);
        check("ar_ready", gd_ready, 1);
        check("ar_occ", dut.occ, 0);
        #1;
        sys_reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
